// File: rtl/fp_rem_iter.sv
// Iterative restoring divider (quotient + remainder), one quotient bit per enabled clock.
// Responder side of the ld/done handshake: idles with done=1, busy while done=0.
module fp_rem_iter #(
   parameter int WID = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           ld,
   input  logic [WID-1:0] a,
   input  logic [WID-1:0] b,
   output logic [WID-1:0] q,
   output logic [WID-1:0] r,
   output logic           dbz,
   output logic           done
);

   localparam int CW = $clog2(WID);

   // Handshake: ld is accepted on an edge with ce=1 while done=1 (IDLE);
   // done stays low until q/r/dbz carry the result of that operation.
   typedef enum logic [1:0] {IDLE, RUN, DBZ} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [WID-1:0] dvd_q, dvd_d;
   logic [WID-1:0] dvs_q, dvs_d;
   logic [WID-1:0] rem_q, rem_d;
   logic [WID-1:0] quo_q, quo_d;
   logic [WID-1:0] q_q, q_d;
   logic [WID-1:0] r_q, r_d;
   logic           dbz_q, dbz_d;
   logic           done_q, done_d;

   logic [WID:0]   diff;
   logic           ge;
   logic [WID-1:0] rem_next;
   logic [WID-1:0] quo_next;

   // Partial remainder stays below the divisor, so its stored copy fits WID bits;
   // only the shifted trial value needs the extra bit, and its borrow is the compare.
   always_comb begin
      diff     = {rem_q, dvd_q[WID-1]} - {1'b0, dvs_q};
      ge       = ~diff[WID];
      rem_next = ge ? diff[WID-1:0] : {rem_q[WID-2:0], dvd_q[WID-1]};
      quo_next = {quo_q[WID-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      done_d  = done_q;
      if (ce) begin
         case (state_q)
            IDLE: begin
               if (ld) begin
                  dvd_d   = a;
                  dvs_d   = b;
                  rem_d   = '0;
                  quo_d   = '0;
                  count_d = CW'(WID - 1);
                  done_d  = 1'b0;
                  state_d = (b == '0) ? DBZ : RUN;
               end
            end
            RUN: begin
               dvd_d   = dvd_q << 1;
               rem_d   = rem_next;
               quo_d   = quo_next;
               count_d = count_q - CW'(1);
               if (count_q == '0) begin
                  q_d     = quo_next;
                  r_d     = rem_next;
                  dbz_d   = 1'b0;
                  done_d  = 1'b1;
                  count_d = '0;
                  state_d = IDLE;
               end
            end
            DBZ: begin
               q_d     = {WID{1'b1}};
               r_d     = dvd_q;
               dbz_d   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign dbz  = dbz_q;
   assign done = done_q;

endmodule

// File: tb/tb_fp_rem_iter.sv
// Bench for fp_rem_iter: vector table plus hand-written handshake, stall and abort sequences.
module tb_fp_rem_iter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst, ce, ld;
   logic [W-1:0] a, b, q, r;
   logic         dbz, done;

   int errors = 0;
   int checks = 0;

   logic [2*W:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edbz;
   } vec_t;

   vec_t vecs[6];

   fp_rem_iter #(.WID(W)) dut (
      .clk(clk), .rst(rst), .ce(ce), .ld(ld), .a(a), .b(b),
      .q(q), .r(r), .dbz(dbz), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts one op, then walks edges E1.. applying optional extra ld pulses,
   // a ce stall window and a reset edge; compares the popped expectation at done.
   task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W:0] exp, input int exp_lat,
                         input int p1, input int p2, input int s0, input int slen,
                         input int rst_at);
      logic [W-1:0] pq, pr;
      logic         pdbz, hold_ok, fin;
      logic [2*W:0] e;
      int           lat;
      pq = q; pr = r; pdbz = dbz; hold_ok = 1'b1; fin = 1'b0; lat = 0;
      exp_q.push_back(exp);
      a = va; b = vb; ld = 1'b1; ce = 1'b1;
      tick;
      ld = 1'b0; a = ~va; b = ~vb;
      chk({name, " busy_after_E0"}, W'(done), '0);
      for (int k = 1; k <= 300 && !fin; k++) begin
         ld = (k == p1) || (k == p2);
         if (ld) begin a = 1; b = 1; end
         ce  = !((k >= s0) && (k < s0 + slen));
         rst = (k == rst_at);
         tick;
         ld = 1'b0; ce = 1'b1;
         if (rst) begin
            rst = 1'b0;
            chk({name, " abort_done"}, W'(done), W'(1));
            chk({name, " abort_q"}, q, '0);
            chk({name, " abort_r"}, r, '0);
            chk({name, " abort_dbz"}, W'(dbz), '0);
            void'(exp_q.pop_front());
            return;
         end
         if (!done) begin
            if (q !== pq || r !== pr || dbz !== pdbz) hold_ok = 1'b0;
         end else begin
            fin = 1'b1;
            lat = k;
         end
      end
      e = exp_q.pop_front();
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s timeout: done still 0 after 300 edges, required done=1", name);
      end else begin
         chk({name, " latency"}, W'(lat), W'(exp_lat));
         chk({name, " hold"}, W'(hold_ok), W'(1));
         chk({name, " q"}, q, e[2*W:W+1]);
         chk({name, " r"}, r, e[W:1]);
         chk({name, " dbz"}, W'(dbz), W'(e[0]));
         checks--;
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst = 1'b1; ce = 1'b1; ld = 1'b0; a = '0; b = '0;
      tick; tick;
      rst = 1'b0;
      chk("reset done", W'(done), W'(1));
      chk("reset q", q, '0);
      chk("reset r", r, '0);
      chk("reset dbz", W'(dbz), '0);
      a = 64'd55; b = 64'd3;
      repeat (10) tick;
      chk("idle done", W'(done), W'(1));
      chk("idle q", q, '0);
      chk("idle r", r, '0);

      vecs[0] = '{a: 64'd100, b: 64'd7, eq: 64'd14, er: 64'd2, edbz: 1'b0};
      vecs[1] = '{a: 64'd5, b: 64'd9, eq: 64'd0, er: 64'd5, edbz: 1'b0};
      vecs[2] = '{a: {W{1'b1}}, b: 64'd1, eq: {W{1'b1}}, er: 64'd0, edbz: 1'b0};
      vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000,
                  eq: 64'd1, er: 64'd0, edbz: 1'b0};
      vecs[4] = '{a: 64'd123, b: 64'd0, eq: {W{1'b1}}, er: 64'd123, edbz: 1'b1};
      vecs[5] = '{a: 64'd9, b: 64'd3, eq: 64'd3, er: 64'd0, edbz: 1'b0};
      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                {vecs[i].eq, vecs[i].er, vecs[i].edbz},
                vecs[i].edbz ? 1 : W, 0, 0, 0, 0, 0);

      ce = 1'b0; ld = 1'b1; a = 64'd77; b = 64'd5;
      tick;
      ce = 1'b1; ld = 1'b0;
      chk("ld_with_ce0 done", W'(done), W'(1));
      chk("ld_with_ce0 q", q, 64'd3);

      run_op("ignored_ld_stall", 64'd1000, 64'd10, {64'd100, 64'd0, 1'b0},
             W + 7, 5, 30, 40, 7, 0);
      run_op("abort", 64'd100, 64'd7, {64'd14, 64'd2, 1'b0}, W, 0, 0, 0, 0, 20);
      run_op("after_abort", 64'd50, 64'd6, {64'd8, 64'd2, 1'b0}, W, 0, 0, 0, 0, 0);

      for (int i = 0; i < 4; i++) begin
         ra = {$urandom, $urandom};
         rb = (i == 3) ? {$urandom, $urandom} | 64'd1 : W'($urandom_range(1, 1000));
         run_op($sformatf("rand%0d", i), ra, rb, {ra / rb, ra % rb, 1'b0}, W, 0, 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
